// File: rtl/adc_spi_avg.sv
// Periodic read-only SPI frame on a 12-bit serial ADC, averaging 2^AVG_LOG2
// samples into an 11-bit display value with a one-clock update strobe.
module adc_spi_avg #(
  parameter int CLK_DIV       = 27,
  parameter int SAMPLE_PERIOD = 270000,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [10:0] num,
  output logic        num_valid
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, ACC} state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic [11:0] sample_q, sample_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0] num_q, num_d;
  logic        valid_q, valid_d;
  logic        tick_s;
  logic        div_last_s;
  logic [AW-1:0] total_s;

  // Free-running conversion period timer.
  always_comb begin
    tick_s = (timer_q == TIMER_LAST);
    if (tick_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Frame sequencing, bit capture and averaging.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    sample_d   = sample_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    valid_d    = 1'b0;
    div_last_s = (div_q == DIV_LAST);
    total_s    = acc_q + AW'(sample_q);
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (tick_s) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (div_last_s) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = 4'd0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT: begin
        if (!div_last_s) begin
          div_d = div_q + DW'(1);
        end else if (!sclk_q) begin
          div_d  = '0;
          sclk_d = 1'b1;
        end else begin
          // End of a high phase: capture; the 16th bit is never shifted in.
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
            cs_n_d  = 1'b1;
          end else begin
            sample_d = {sample_q[10:0], adc_dout};
            bit_d    = bit_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (div_last_s) begin
          state_d = ACC;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ACC: begin
        state_d = IDLE;
        if (cnt_q == CNT_LAST) begin
          num_d   = 11'(total_s >> (AVG_LOG2 + 1));
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = total_s;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      div_q    <= '0;
      bit_q    <= 4'd0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sample_q <= 12'd0;
      acc_q    <= '0;
      cnt_q    <= '0;
      num_q    <= 11'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign num       = num_q;
  assign num_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_avg.sv
// Bench for adc_spi_avg: two instances (4-sample and 1-sample averaging),
// serial ADC models, a frame-level reference model and per-cycle compare.
module tb_adc_spi_avg;

  localparam int CD = 2;
  localparam int SP = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic dout0 = 1'b0, dout1 = 1'b0;
  logic cs0, cs1, sclk0, sclk1, v0, v1;
  logic [10:0] num0, num1;

  int n_cmp = 0;
  int n_bad = 0;

  adc_spi_avg #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_LOG2(2)) dut0 (
    .clk(clk), .rst(rst0), .adc_dout(dout0), .adc_cs_n(cs0),
    .adc_sclk(sclk0), .num(num0), .num_valid(v0));

  adc_spi_avg #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_LOG2(0)) dut1 (
    .clk(clk), .rst(rst1), .adc_dout(dout1), .adc_cs_n(cs1),
    .adc_sclk(sclk1), .num(num1), .num_valid(v1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial ADC models: 3 leading zeros, 12 data bits MSB first, changes after SCLK fall.
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] cur0 = 12'd0, cur1 = 12'd0;
  logic [15:0] sh0 = 16'd0, sh1 = 16'd0;

  always @(negedge cs0) begin
    if (q0.size() > 0) cur0 = q0.pop_front();
    sh0   = {3'b000, cur0, 1'b0};
    dout0 = sh0[15];
  end
  always @(negedge sclk0) begin
    #1;
    sh0   = {sh0[14:0], 1'b0};
    dout0 = sh0[15];
  end
  always @(negedge cs1) begin
    if (q1.size() > 0) cur1 = q1.pop_front();
    sh1   = {3'b000, cur1, 1'b0};
    dout1 = sh1[15];
  end
  always @(negedge sclk1) begin
    #1;
    sh1   = {sh1[14:0], 1'b0};
    dout1 = sh1[15];
  end

  // Reference model and per-cycle compare for both lanes.
  int   lg[2]       = '{2, 0};
  int   acc_sum[2]  = '{0, 0};
  int   acc_n[2]    = '{0, 0};
  int   cd[2]       = '{0, 0};
  int   pend[2]     = '{0, 0};
  int   exp_num[2]  = '{0, 0};
  int   low_cnt[2]  = '{0, 0};
  int   rise_cnt[2] = '{0, 0};
  logic prev_cs[2]   = '{1'b1, 1'b1};
  logic prev_sclk[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic r, cs, sc, vv;
    logic [10:0] nm;
    logic [11:0] cv;
    int ev;
    for (int i = 0; i < 2; i++) begin
      r  = (i == 0) ? rst0  : rst1;
      cs = (i == 0) ? cs0   : cs1;
      sc = (i == 0) ? sclk0 : sclk1;
      vv = (i == 0) ? v0    : v1;
      nm = (i == 0) ? num0  : num1;
      cv = (i == 0) ? cur0  : cur1;
      if (!r) begin
        acc_sum[i] = 0; acc_n[i] = 0; cd[i] = 0; exp_num[i] = 0;
        low_cnt[i] = 0; rise_cnt[i] = 0;
        chk("reset_cs_n", 32'(cs), 32'd1);
        chk("reset_sclk", 32'(sc), 32'd0);
        chk("reset_num", 32'(nm), 32'd0);
        chk("reset_valid", 32'(vv), 32'd0);
        prev_cs[i]   = 1'b1;
        prev_sclk[i] = 1'b0;
      end else begin
        ev = 0;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin
            exp_num[i] = pend[i];
            ev = 1;
          end
        end
        if (cs) begin
          chk("sclk_idle_low", 32'(sc), 32'd0);
        end else begin
          low_cnt[i]++;
          if (!prev_sclk[i] && sc) rise_cnt[i]++;
        end
        if (!prev_cs[i] && cs) begin
          chk("cs_low_clks", 32'(low_cnt[i]), 32'(33 * CD));
          chk("sclk_rises", 32'(rise_cnt[i]), 32'd16);
          acc_sum[i] += int'(cv);
          acc_n[i]++;
          if (acc_n[i] == (1 << lg[i])) begin
            pend[i]    = acc_sum[i] >> (lg[i] + 1);
            cd[i]      = CD + 1;
            acc_sum[i] = 0;
            acc_n[i]   = 0;
          end
          low_cnt[i]  = 0;
          rise_cnt[i] = 0;
        end
        chk((i == 0) ? "num_lane0" : "num_lane1", 32'(nm), 32'(exp_num[i]));
        chk((i == 0) ? "valid_lane0" : "valid_lane1", 32'(vv), 32'(ev));
        prev_cs[i]   = cs;
        prev_sclk[i] = sc;
      end
    end
  end

  task automatic wait_valid(input int lane, input logic [10:0] exp, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (((lane == 0) ? v0 : v1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      chk(name, 32'((lane == 0) ? num0 : num1), 32'(exp));
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no num_valid pulse within 700 clks, expected num %0d", name, exp);
    end
  endtask

  initial begin
    int k;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (4) q0.push_back(12'hFFF);
    q0.push_back(12'd100); q0.push_back(12'd200);
    q0.push_back(12'd300); q0.push_back(12'd401);
    repeat (4) q0.push_back(12'h800);
    q0.push_back(12'h400);
    q1.push_back(12'h7FE); q1.push_back(12'h001);
    q1.push_back(12'h555); q1.push_back(12'hABC); q1.push_back(12'h123);

    repeat (3) @(negedge clk);
    #2;
    rst0 = 1'b1;
    rst1 = 1'b1;

    k = 0;
    while (cs0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("first_frame_start", 32'(k), 32'(SP));

    wait_valid(1, 11'd1023, "no_avg_7FE");
    wait_valid(1, 11'd0,    "no_avg_001");
    wait_valid(0, 11'd2047, "full_scale");
    wait_valid(0, 11'd125,  "mixed_avg");
    wait_valid(0, 11'd1024, "avg_800");

    // Reset lane 0 during the 8th SCLK high phase of its next frame.
    k = 0;
    while (cs0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    for (int t = 0; t < 200 && k < 8; t++) begin
      @(negedge clk);
      if (sclk0 && !prev_sclk[0]) k++;
    end
    chk("reached_8th_sclk", 32'(k), 32'd8);
    #1;
    rst0 = 1'b0;
    #1;
    chk("async_cs_n", 32'(cs0), 32'd1);
    chk("async_sclk", 32'(sclk0), 32'd0);
    chk("async_num", 32'(num0), 32'd0);
    chk("async_valid", 32'(v0), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst0 = 1'b1;

    wait_valid(0, 11'd512, "after_reset_400");
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
